// File: rtl/alu_hs.sv
// alu_hs: handshaked ALU sitting between operand read and writeback.
//
// Single-cycle ops (logic, arithmetic, shifts, compares) produce a result the
// cycle after they are accepted. With the macro ALU_HS_MULDIV_EN defined, the
// opcodes MUL/MULHU/DIVU/REMU (17..20) run on an iterative shift-add /
// restoring-divide unit taking W steps. Without the macro those opcodes are
// reported as illegal and no multiply/divide hardware is built.
//
// Handshake: a request moves when in_valid && in_ready; a result moves when
// out_valid && out_ready. out_valid stays high, and res/carry/z/err stay
// stable, until the result is taken (or reset).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready request handshake
//   op, op1, op2      opcode and operands (captured at accept)
//   out_valid/out_ready result handshake
//   res, carry, z, err result, carry/borrow, zero flag, illegal-op flag
module alu_hs #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic         carry,
    output logic         z,
    output logic         err
);
    localparam int SHW = $clog2(W);

    localparam logic [4:0] OP_LHI = 5'd0,  OP_ADD = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4,  OP_XOR = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SELZ = 5'd8, OP_SELNZ = 5'd9, OP_SEQ = 5'd10, OP_SLE  = 5'd11;
    localparam logic [4:0] OP_SLT = 5'd12, OP_SNE = 5'd13, OP_SRA  = 5'd14, OP_INC4 = 5'd15;
    localparam logic [4:0] OP_SLTS = 5'd16, OP_MUL = 5'd17, OP_MULHU = 5'd18;
    localparam logic [4:0] OP_DIVU = 5'd19, OP_REMU = 5'd20;

`ifdef ALU_HS_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t         state_q, state_d;
    logic [W-1:0]   res_q, res_d;
    logic           carry_q, carry_d, z_q, z_d, err_q, err_d;

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0] sh;
    logic [W:0]     alu_w;      // {carry, result}
    logic           illegal;
    logic           is_muldiv;

    assign sh = op2[SHW-1:0];

    always_comb begin
        alu_w     = '0;
        illegal   = 1'b0;
        is_muldiv = 1'b0;
        case (op)
            OP_LHI:   alu_w = {1'b0, op2 << (W/2)};
            OP_ADD:   alu_w = {1'b0, op1} + {1'b0, op2};
            OP_SUB:   alu_w = {1'b0, op1} - {1'b0, op2};   // bit W = borrow
            OP_AND:   alu_w = {1'b0, op1 & op2};
            OP_OR:    alu_w = {1'b0, op1 | op2};
            OP_XOR:   alu_w = {1'b0, op1 ^ op2};
            OP_SLL:   alu_w = {1'b0, op1 << sh};
            OP_SRL:   alu_w = {1'b0, op1 >> sh};
            OP_SRA:   alu_w = {1'b0, $signed(op1) >>> sh};
            OP_SELZ:  alu_w = {1'b0, (op1 == {W{1'b0}}) ? op2 : {W{1'b0}}};
            OP_SELNZ: alu_w = {1'b0, (op1 != {W{1'b0}}) ? op2 : {W{1'b0}}};
            OP_SEQ:   alu_w = {{W{1'b0}}, op1 == op2};
            OP_SLE:   alu_w = {{W{1'b0}}, op1 <= op2};
            OP_SLT:   alu_w = {{W{1'b0}}, op1 < op2};
            OP_SNE:   alu_w = {{W{1'b0}}, op1 != op2};
            OP_INC4:  alu_w = {1'b0, op1} + (W+1)'(4);
            OP_SLTS:  alu_w = {{W{1'b0}}, $signed(op1) < $signed(op2)};
`ifdef ALU_HS_MULDIV_EN
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: is_muldiv = 1'b1;
`endif
            default:  illegal = 1'b1;
        endcase
    end

`ifdef ALU_HS_MULDIV_EN
    // ---------------- iterative multiply / divide ----------------
    // md_kind: 0 MUL, 1 MULHU, 2 DIVU, 3 REMU. Bit 1 selects divide, bit 0
    // selects the high half (product high / remainder) as the result.
    // Multiply: {hi,lo} starts as {0, multiplier}; each step adds the
    // multiplicand into hi when lo[0] is set, then shifts {carry,hi,lo} right.
    // Divide: lo starts as the dividend, hi is the partial remainder; each step
    // shifts one dividend bit into hi and subtracts the divisor if it fits.
    // A zero divisor always "fits", giving an all-ones quotient and a
    // remainder equal to the dividend without special casing.
    logic [1:0]     md_kind_q, md_kind_d;
    logic [W-1:0]   md_a_q, md_a_d, md_hi_q, md_hi_d, md_lo_q, md_lo_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [1:0]     op_kind;
    logic [W:0]     mul_sum, div_sh;
    logic [W-1:0]   step_hi, step_lo, md_res;

    localparam logic [SHW-1:0] LAST = SHW'(W - 1);

    assign op_kind = 2'(op - OP_MUL);

    always_comb begin
        mul_sum = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_a_q} : {(W+1){1'b0}});
        div_sh  = {md_hi_q, md_lo_q[W-1]};
        if (!md_kind_q[1]) begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], md_lo_q[W-1:1]};
        end else if (div_sh >= {1'b0, md_a_q}) begin
            step_hi = W'(div_sh - {1'b0, md_a_q});
            step_lo = {md_lo_q[W-2:0], 1'b1};
        end else begin
            step_hi = div_sh[W-1:0];
            step_lo = {md_lo_q[W-2:0], 1'b0};
        end
        md_res = md_kind_q[0] ? step_hi : step_lo;
    end
`endif

    // ---------------- control FSM ----------------
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        carry_d  = carry_q;
        z_d      = z_q;
        err_d    = err_q;
        in_ready = 1'b0;
`ifdef ALU_HS_MULDIV_EN
        md_kind_d = md_kind_q;
        md_a_d    = md_a_q;
        md_hi_d   = md_hi_q;
        md_lo_d   = md_lo_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: in_ready = 1'b1;
            DONE: begin
                // A result being taken frees the slot in the same cycle.
                in_ready = out_ready;
                if (out_ready) state_d = IDLE;
            end
`ifdef ALU_HS_MULDIV_EN
            BUSY: begin
                md_hi_d = step_hi;
                md_lo_d = step_lo;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    res_d   = md_res;
                    carry_d = 1'b0;
                    z_d     = (md_res == {W{1'b0}});
                    err_d   = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (in_valid && in_ready) begin
`ifdef ALU_HS_MULDIV_EN
            if (is_muldiv) begin
                state_d   = BUSY;
                cnt_d     = '0;
                md_kind_d = op_kind;
                md_a_d    = op_kind[1] ? op2 : op1;
                md_lo_d   = op_kind[1] ? op1 : op2;
                md_hi_d   = '0;
            end else
`endif
            begin
                state_d = DONE;
                res_d   = alu_w[W-1:0];
                carry_d = alu_w[W];
                z_d     = (alu_w[W-1:0] == {W{1'b0}});
                err_d   = illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            carry_q <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_HS_MULDIV_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_kind_q <= '0;
            md_a_q    <= '0;
            md_hi_q   <= '0;
            md_lo_q   <= '0;
            cnt_q     <= '0;
        end else begin
            md_kind_q <= md_kind_d;
            md_a_q    <= md_a_d;
            md_hi_q   <= md_hi_d;
            md_lo_q   <= md_lo_d;
            cnt_q     <= cnt_d;
        end
    end
`endif

    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign carry     = carry_q;
    assign z         = z_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_hs.sv
// Self-checking bench for alu_hs (W=32). A reference model computes every
// accepted request's result from plain arithmetic; a negedge monitor compares
// the DUT against it whenever out_valid is high. Directed tests add literal
// expectations, latency, backpressure and reset checks.
module tb_alu_hs;
    localparam int W = 32;
    localparam int NB = 18;

    localparam logic [4:0] OP_LHI = 5'd0, OP_ADD = 5'd1, OP_SUB = 5'd2, OP_OR = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5, OP_SLL = 5'd6, OP_SLT = 5'd12, OP_SRA = 5'd14;
    localparam logic [4:0] OP_SLTS = 5'd16, OP_MUL = 5'd17, OP_MULHU = 5'd18;
    localparam logic [4:0] OP_DIVU = 5'd19, OP_REMU = 5'd20;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready;
    logic         carry, z, err;
    logic [4:0]   op;
    logic [W-1:0] op1, op2, res;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    logic [W+1:0] exp_q[$];     // {err, carry, res}
    logic [W+1:0] mon_ex;

    // Directed burst vectors: single-cycle ops only, issued back to back.
    logic [4:0]   bo [NB] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd14,
                              5'd8, 5'd8, 5'd9, 5'd10, 5'd11, 5'd13, 5'd15, 5'd16, 5'd31};
    logic [W-1:0] ba [NB] = '{32'h0, 32'h7FFFFFFF, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0,
                              32'h12345678, 32'h1, 32'h80000000, 32'h7FFFFFFF, 32'h0,
                              32'h3, 32'h3, 32'h9, 32'hA, 32'h1, 32'hFFFFFFFE, 32'h1, 32'h7};
    logic [W-1:0] bb [NB] = '{32'hFFFF0001, 32'h1, 32'h5, 32'hFF00FF00, 32'hFF00FF00,
                              32'h12345678, 32'h20, 32'h1F, 32'h1F, 32'h55,
                              32'h55, 32'h66, 32'h9, 32'h9, 32'h2, 32'h0, 32'hFFFFFFFF, 32'h8};

    alu_hs #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .carry     (carry),
        .z         (z),
        .err       (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input logic [4:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0]   r;
        logic           c, e;
        logic [2*W-1:0] p;
        logic [W-1:0]   msb;
        int             sh;
        r   = '0;
        c   = 1'b0;
        e   = 1'b0;
        sh  = int'(b % W);
        msb = {1'b1, {(W-1){1'b0}}};
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            5'd0:  r = b << (W/2);
            5'd1:  begin r = a + b; c = (r < a); end
            5'd2:  begin r = a - b; c = (a < b); end
            5'd3:  r = a & b;
            5'd4:  r = a | b;
            5'd5:  r = a ^ b;
            5'd6:  r = a << sh;
            5'd7:  r = a >> sh;
            5'd14: begin r = a >> sh; if (a[W-1]) r = r | ~({W{1'b1}} >> sh); end
            5'd8:  r = (a == 0) ? b : '0;
            5'd9:  r = (a != 0) ? b : '0;
            5'd10: r = W'(a == b);
            5'd11: r = W'(a <= b);
            5'd12: r = W'(a < b);
            5'd13: r = W'(a != b);
            5'd15: begin r = a + 4; c = (r < a); end
            5'd16: r = W'((a ^ msb) < (b ^ msb));
`ifdef ALU_HS_MULDIV_EN
            5'd17: r = p[W-1:0];
            5'd18: r = p[2*W-1:W];
            5'd19: r = (b == 0) ? {W{1'b1}} : a / b;
            5'd20: r = (b == 0) ? a : a % b;
`endif
            default: e = 1'b1;
        endcase
        return {e, c, r};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL stale_result: out_valid=1 res=%h with nothing outstanding (required out_valid=0)", res);
                end else begin
                    mon_ex = exp_q[0];
                    if (res !== mon_ex[W-1:0] || carry !== mon_ex[W] || err !== mon_ex[W+1] ||
                        z !== (mon_ex[W-1:0] == '0)) begin
                        n_miss++;
                        $display("FAIL model_cmp: got res=%h c=%b z=%b e=%b, required res=%h c=%b z=%b e=%b",
                                 res, carry, z, err, mon_ex[W-1:0], mon_ex[W],
                                 (mon_ex[W-1:0] == '0), mon_ex[W+1]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, op1, op2));
                n_vec++;
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Presents a request from posedge+1 and returns at posedge+1 after accept.
    task automatic issue(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        @(posedge clk); #1;
        op = o; op1 = a; op2 = b; in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_cmp++; n_miss++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; lat counts cycles after the accept cycle.
    task automatic wait_result(output logic [W-1:0] r, output logic c, output logic zz,
                               output logic e, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        r = res; c = carry; zz = z; e = err;
        if (!out_valid) begin
            n_cmp++; n_miss++;
            $display("FAIL result_timeout: out_valid=0 after %0d cycles, required 1", lat);
        end
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input string name, input logic [4:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                       input logic ee, input int el);
        logic [W-1:0] r;
        logic         c, zz, e;
        int           lat;
        issue(o, a, b);
        wait_result(r, c, zz, e, lat);
        check({name, ".res"}, 64'(r), 64'(er));
        check({name, ".carry"}, 64'(c), 64'(ec));
        check({name, ".z"}, 64'(zz), 64'(er == '0));
        check({name, ".err"}, 64'(e), 64'(ee));
        check({name, ".latency"}, 64'(lat), 64'(el));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] r;
        logic         c, zz, e;
        int           lat, acc, cnt_v;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.res", 64'(res), 64'd0);
        check("reset.carry", 64'(carry), 64'd0);
        check("reset.z", 64'(z), 64'd0);
        check("reset.err", 64'(err), 64'd0);

        run("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
        run("sub_borrow", OP_SUB, 32'h3, 32'h5, 32'hFFFFFFFE, 1'b1, 1'b0, 1);
        run("sll_31", OP_SLL, 32'h1, 32'd31, 32'h80000000, 1'b0, 1'b0, 1);
        run("sra_4", OP_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 1);
        run("lhi", OP_LHI, 32'h0, 32'h1234, 32'h12340000, 1'b0, 1'b0, 1);
        run("slts", OP_SLTS, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1);
        run("slt", OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1);
        run("illegal25", 5'd25, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1, 1);

`ifdef ALU_HS_MULDIV_EN
        run("mul", OP_MUL, 32'h10000, 32'h10000, 32'h0, 1'b0, 1'b0, W + 1);
        run("mulhu", OP_MULHU, 32'h10000, 32'h10000, 32'h1, 1'b0, 1'b0, W + 1);
        run("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, W + 1);
        run("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, W + 1);
        run("divu_by0", OP_DIVU, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, W + 1);
        run("remu_by0", OP_REMU, 32'h1234, 32'h0, 32'h1234, 1'b0, 1'b0, W + 1);
        run("mul_big", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, W + 1);
        run("mulhu_big", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, W + 1);
`else
        run("mul_off", OP_MUL, 32'h10000, 32'h10000, 32'h0, 1'b0, 1'b1, 1);
        run("mulhu_off", OP_MULHU, 32'h3, 32'h4, 32'h0, 1'b0, 1'b1, 1);
        run("divu_off", OP_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 1'b1, 1);
        run("remu_off", OP_REMU, 32'd100, 32'd7, 32'h0, 1'b0, 1'b1, 1);
`endif

        // Back-to-back single-cycle ops: one accept per cycle.
        @(posedge clk); #1;
        acc = 0;
        for (int i = 0; i < NB; i++) begin
            op = bo[i]; op1 = ba[i]; op2 = bb[i]; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("burst.accepts", 64'(acc), 64'(NB));
        @(negedge clk);
        @(posedge clk); #1;

        // Backpressure: result held, no new accept while out_ready=0.
        out_ready = 1'b0;
        issue(OP_ADD, 32'd2, 32'd2);
        wait_result(r, c, zz, e, lat);
        check("bp.res", 64'(r), 64'd4);
        @(posedge clk); #1;
        op = OP_XOR; op1 = 32'hA5; op2 = 32'hFF; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.hold_res", 64'(res), 64'd4);
            check("bp.hold_valid", 64'(out_valid), 64'd1);
            check("bp.in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.same_cycle_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp.next_valid", 64'(out_valid), 64'd1);
        check("bp.next_res", 64'(res), 64'h5A);
        @(posedge clk); #1;

        // Reset while a result waits in DONE.
        out_ready = 1'b0;
        issue(OP_OR, 32'h1, 32'h2);
        wait_result(r, c, zz, e, lat);
        check("rst_done.res_before", 64'(r), 64'd3);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_done.out_valid", 64'(out_valid), 64'd0);
        check("rst_done.in_ready", 64'(in_ready), 64'd1);
        check("rst_done.res", 64'(res), 64'd0);
        check("rst_done.err", 64'(err), 64'd0);
        out_ready = 1'b1;

`ifdef ALU_HS_MULDIV_EN
        // Reset mid-divide: no result may ever emerge.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_divu.out_valid", 64'(out_valid), 64'd0);
        check("rst_divu.in_ready", 64'(in_ready), 64'd1);
        cnt_v = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) cnt_v++;
        end
        check("rst_divu.no_stale", 64'(cnt_v), 64'd0);
`endif

        run("post_reset_add", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        n_miss++;
        $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/alu_hs.md
Name: alu_hs

Overview:
- Parametrised, handshaked successor to the datapath single-cycle ALU.
- Single-cycle logic, arithmetic and compare ops complete in 1 cycle.
- Optional iterative multiply/divide unit completes in W cycles behind a small FSM.
- Sits between decode/operand-read and writeback; stalls upstream via in_ready and tolerates writeback backpressure via out_ready.

Parameters:
- W, 32, datapath width; must be even and >= 8.
- SHW, $clog2(W), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  request accepted when in_valid && in_ready
- op  in  5  opcode
- op1  in  W  operand 1
- op2  in  W  operand 2
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result when out_valid && out_ready
- res  out  W  result
- carry  out  1  carry/borrow flag
- z  out  1  res == 0
- err  out  1  illegal or unsupported opcode

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; out_valid=0, res=0, carry=0, z=0, err=0. An in-flight MUL/DIV is aborted and no result is produced.
- Opcodes:
  - 0 LHI = op2<<(W/2)
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 SLL / 7 SRL / 14 SRA, shifting op1 by op2[SHW-1:0] (full range, not mod 8)
  - 8 = (op1==0 ? op2 : 0); 9 = (op1!=0 ? op2 : 0)
  - 10 SEQ, 11 SLE, 12 SLT, 13 SNE: unsigned compare; true result = 1 (LSB only), false = 0
  - 15 INC4 = op1+4
  - 16 SLTS: signed less-than
  - 17 MUL (low W bits), 18 MULHU (high W bits, unsigned), 19 DIVU, 20 REMU
  - 21..31 illegal
- Arithmetic: ADD, SUB and INC4 are computed W+1 bits wide; carry = bit W (for SUB, 1 = borrow). All other ops give carry=0. z is computed from the final res for every op.
- Illegal opcode: res=0, carry=0, z=1, err=1; completes with 1-cycle latency. err=0 for all legal ops.
- FSM states:
  - IDLE: in_ready=1. Accepting a single-cycle op goes to DONE next cycle. Accepting ops 17-20 goes to BUSY with counter=0.
  - BUSY: in_ready=0. One shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter increments. When counter==W-1 the step completes and the FSM goes to DONE. Latency from accept to out_valid is W+1 cycles.
  - DONE: out_valid=1; res, carry, z and err held stable until out_ready=1.
    - On out_ready: if in_valid, accept the new op the same cycle (in_ready = out_ready in DONE) and go to DONE or BUSY as above; otherwise go to IDLE.
- Throughput: back-to-back single-cycle ops achieve 1 op/cycle while out_ready=1.
- Divide by zero:
  - DIVU gives quotient all-ones.
  - REMU gives remainder op1.
  - Fixed W-cycle latency, no early exit.
- Operands are captured at accept; op1/op2 may change while BUSY.
- out_valid never drops without a handshake, except on reset.

Optional Feature:
- Macro ALU_HS_MULDIV_EN.
- Defined: opcodes 17-20 are legal and the BUSY state, counter and W-bit multiplier/divider registers are built.
- Undefined: opcodes 17-20 behave as illegal (res=0, z=1, err=1, 1-cycle latency); no BUSY state or MUL/DIV registers are synthesised.

Test Plan:
- W=32, ADD 0xFFFFFFFF+1, out_ready=1 -> next cycle out_valid=1, res=0, carry=1, z=1, err=0; SUB 3-5 -> res=0xFFFFFFFE, carry=1.
- SLL op1=1, op2=31 -> res=0x80000000 (verifies full shift range); SRA 0x80000000 by 4 -> 0xF8000000; LHI op2=0x1234 -> 0x12340000.
- SLTS op1=0xFFFFFFFF, op2=1 -> res=1; SLT with the same operands -> res=0; illegal op 25 -> res=0, z=1, err=1.
- With MULDIV_EN: MUL 0x10000*0x10000 -> res=0 and z=1 after exactly 33 cycles; MULHU of the same -> res=1; DIVU 100/7 -> 14; REMU -> 2; DIVU x/0 -> 0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 2+2 -> res=4 stable, in_ready=0, no new accept; raise out_ready with in_valid=1 -> next op accepted the same cycle.
- Reset: assert rst_n=0 mid-DIVU (cycle 10) -> next cycle out_valid=0, in_ready=1; no stale result ever appears.
